// File: rtl/mem_arbiter.sv
// ============================================================================
//  Module   : mem_arbiter
//  Purpose  : Two-port arbiter sharing one RAM between the instruction CMU
//             (port 0) and the data CMU (port 1). A granted port owns the RAM
//             for up to BURST_LEN acked beats. Every burst is followed by at
//             least one idle cycle.
//  Config   : MEM_ARBITER_RR_EN defined   -> round-robin on contention
//             MEM_ARBITER_RR_EN undefined -> fixed priority, port 1 wins
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_arbiter #(
    parameter int BURST_LEN = 4,
    parameter int AW        = 32,
    parameter int DW        = 32
) (
    input  logic          clk,
    input  logic          rst,

    input  logic          p0_cs,
    input  logic          p0_we,
    input  logic [AW-1:0] p0_addr,
    input  logic [DW-1:0] p0_din,
    output logic [DW-1:0] p0_dout,
    output logic          p0_ack,

    input  logic          p1_cs,
    input  logic          p1_we,
    input  logic [AW-1:0] p1_addr,
    input  logic [DW-1:0] p1_din,
    output logic [DW-1:0] p1_dout,
    output logic          p1_ack,

    output logic          ram_cs,
    output logic          ram_we,
    output logic [AW-1:0] ram_addr,
    output logic [DW-1:0] ram_din,
    input  logic [DW-1:0] ram_dout,
    input  logic          ram_ack,

    output logic [1:0]    grant
);

    // Beat counter is at least two bits wide so short bursts still count cleanly.
    localparam int              BEAT_W    = ($clog2(BURST_LEN) > 2) ? $clog2(BURST_LEN) : 2;
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BURST_LEN - 1);
    localparam logic [BEAT_W-1:0] BEAT_ONE  = BEAT_W'(1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } state_t;

    state_t            state;
    logic [BEAT_W-1:0] beat;
    logic              pick_p1;   // arbitration result when leaving IDLE
    logic              own_cs;    // cs of whichever port currently owns the RAM

    // Both ports always see the RAM read data; the ack tells them whose it is.
    assign p0_dout = ram_dout;
    assign p1_dout = ram_dout;

    assign own_cs = (state == OWN1) ? p1_cs : p0_cs;

`ifdef MEM_ARBITER_RR_EN
    // last_grant: 0 = port 0 held the RAM last, 1 = port 1 held it last.
    logic last_grant;

    // On contention the port that did not own the previous burst wins.
    assign pick_p1 = p1_cs & (~p0_cs | ~last_grant);

    // Remember the owner each time a new grant is issued from IDLE.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last_grant <= 1'b1;
        end else if ((state == IDLE) && (p0_cs || p1_cs)) begin
            last_grant <= pick_p1;
        end
    end
`else
    // Fixed priority: the data CMU wins whenever it asks.
    assign pick_p1 = p1_cs;
`endif

    // Ownership FSM with registered grant and beat counter.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            beat  <= '0;
            grant <= 2'b00;
        end else begin
            case (state)
                IDLE: begin
                    beat <= '0;
                    if (p0_cs || p1_cs) begin
                        if (pick_p1) begin
                            state <= OWN1;
                            grant <= 2'b10;
                        end else begin
                            state <= OWN0;
                            grant <= 2'b01;
                        end
                    end
                end
                OWN0, OWN1: begin
                    // Owner withdrew, or the last beat of the line was acked:
                    // release and force one idle cycle before the next grant.
                    if (!own_cs || (ram_ack && (beat == LAST_BEAT))) begin
                        state <= IDLE;
                        grant <= 2'b00;
                        beat  <= '0;
                    end else if (ram_ack) begin
                        beat <= beat + BEAT_ONE;
                    end
                end
                default: begin
                    state <= IDLE;
                    grant <= 2'b00;
                    beat  <= '0;
                end
            endcase
        end
    end

    // Route the owning port onto the RAM bus and steer the ack back to it.
    always_comb begin
        ram_cs   = 1'b0;
        ram_we   = 1'b0;
        ram_addr = '0;
        ram_din  = '0;
        p0_ack   = 1'b0;
        p1_ack   = 1'b0;
        case (state)
            OWN0: begin
                ram_cs   = p0_cs;
                ram_we   = p0_we;
                ram_addr = p0_addr;
                ram_din  = p0_din;
                p0_ack   = ram_ack;
            end
            OWN1: begin
                ram_cs   = p1_cs;
                ram_we   = p1_we;
                ram_addr = p1_addr;
                ram_din  = p1_din;
                p1_ack   = ram_ack;
            end
            default: begin
                ram_cs   = 1'b0;
            end
        endcase
    end

endmodule

`default_nettype wire
